// File: rtl/rv32i_types.sv
// rv32i_types: shared pipeline types for the stall/flush controller
package rv32i_types;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_trk_state_t;
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic load_id_ex;
    logic load_ex_mem;
    logic load_mem_wb;
    logic flush_if_id;
    logic flush_id_ex;
  } pipe_ctrl_t;
endpackage

// File: rtl/mem_resp_tracker.sv
// mem_resp_tracker: remembers a memory response that arrived while the pipeline was stalled
module mem_resp_tracker
  import rv32i_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic resp,
  input  logic advance,
  output logic ok,
  output logic mask
);
  mem_trk_state_t state, state_nx;
  assign ok = ~req | resp | (state == DONE);
  // next state: a response is parked in DONE until the pipeline advances
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req ? (resp ? (advance ? IDLE : DONE) : BUSY) : IDLE;
      BUSY:    state_nx = resp ? (advance ? IDLE : DONE) : BUSY;
      DONE:    state_nx = advance ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  // state and registered mask, mask high exactly while in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mask  <= 1'b0;
    end else begin
      state <= state_nx;
      mask  <= state_nx == DONE;
    end
  end
endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush controller for the 5-stage rv32i pipeline; PIPE_PERF_CNT_EN enables perf counters
module pipeline_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_read,
  input  logic          imem_resp,
  input  logic          dmem_read,
  input  logic          dmem_write,
  input  logic          dmem_resp,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic          id_uses_rs1,
  input  logic          id_uses_rs2,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_mem_read,
  input  logic          ex_br_taken,
  output logic          load_pc,
  output logic          load_if_id,
  output logic          load_id_ex,
  output logic          load_ex_mem,
  output logic          load_mem_wb,
  output logic          flush_if_id,
  output logic          flush_id_ex,
  output logic          imem_mask,
  output logic          dmem_mask,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_bubble,
  output logic [CNT_W-1:0] perf_flush
);
  logic imem_ok, dmem_ok, advance, go, hazard, bub, redir;
  pipe_ctrl_t ctrl;
  mem_resp_tracker u_imem (
    .clk(clk), .rst(rst), .req(imem_read), .resp(imem_resp),
    .advance(advance), .ok(imem_ok), .mask(imem_mask)
  );
  mem_resp_tracker u_dmem (
    .clk(clk), .rst(rst), .req(dmem_read | dmem_write), .resp(dmem_resp),
    .advance(advance), .ok(dmem_ok), .mask(dmem_mask)
  );
  assign advance = imem_ok & dmem_ok;
  assign go      = advance & ~rst;
  assign hazard  = ex_mem_read & (ex_rd != '0) &
                   ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
  assign redir   = go & ex_br_taken;
  assign bub     = go & ~ex_br_taken & hazard;
  // stage enables and bubble strobes; redirect wins over load-use since ID is wrong-path
  always_comb begin
    ctrl             = '0;
    ctrl.load_pc     = go & ~bub;
    ctrl.load_if_id  = go & ~bub;
    ctrl.load_id_ex  = go;
    ctrl.load_ex_mem = go;
    ctrl.load_mem_wb = go;
    ctrl.flush_if_id = redir;
    ctrl.flush_id_ex = redir | bub;
  end
  assign {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex} = ctrl;
`ifdef PIPE_PERF_CNT_EN
  // saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall  <= '0;
      perf_bubble <= '0;
      perf_flush  <= '0;
    end else begin
      if (!advance && perf_stall != '1) perf_stall <= perf_stall + 1'b1;
      if (bub && perf_bubble != '1) perf_bubble <= perf_bubble + 1'b1;
      if (redir && perf_flush != '1) perf_flush <= perf_flush + 1'b1;
    end
  end
`else
  assign perf_stall  = '0;
  assign perf_bubble = '0;
  assign perf_flush  = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;
`ifdef PIPE_PERF_CNT_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] ALL  = 7'b1111100;
  localparam logic [6:0] BUB  = 7'b0011101;
  localparam logic [6:0] RED  = 7'b1111111;
  logic clk = 0, rst = 1;
  logic imem_read = 0, imem_resp = 0, dmem_read = 0, dmem_write = 0, dmem_resp = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0, ex_br_taken = 0;
  logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex;
  logic imem_mask, dmem_mask;
  logic [31:0] perf_stall, perf_bubble, perf_flush;
  int total = 0, bad = 0;
  pipeline_ctrl #(.NUM_REGS(32), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_br_taken(ex_br_taken),
    .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
    .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .imem_mask(imem_mask), .dmem_mask(dmem_mask),
    .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_flush(perf_flush)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_ctrl(input string tag, input logic [6:0] exp);
    chk(tag, {25'd0, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex}, {25'd0, exp});
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #2;
    chk_ctrl("rst_ctrl", NONE);
    chk("rst_imask", {31'd0, imem_mask}, 0);
    chk("rst_dmask", {31'd0, dmem_mask}, 0);
    chk("rst_stall", perf_stall, 0);
    @(negedge clk);
    rst = 0;
    cyc();
    imem_read = 1; imem_resp = 1; dmem_read = 1; dmem_resp = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_ctrl("nolat_ctrl", ALL);
      cyc();
    end
    dmem_read = 0; dmem_resp = 0; imem_resp = 0;
    chk("nolat_stall", perf_stall, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_ctrl("ilat_stall_ctrl", NONE);
      cyc();
    end
    imem_resp = 1;
    @(negedge clk);
    chk_ctrl("ilat_resp_ctrl", ALL);
    cyc();
    imem_resp = 0;
    chk("ilat_stall", perf_stall, PERF * 3);
    chk("ilat_imask", {31'd0, imem_mask}, 0);
    dmem_read = 1;
    @(negedge clk);
    chk_ctrl("mix_c1", NONE);
    cyc();
    dmem_resp = 1;
    @(negedge clk);
    chk_ctrl("mix_c2", NONE);
    chk("mix_c2_dmask", {31'd0, dmem_mask}, 0);
    cyc();
    dmem_resp = 0;
    for (int i = 3; i <= 4; i++) begin
      @(negedge clk);
      chk_ctrl("mix_hold_ctrl", NONE);
      chk("mix_hold_dmask", {31'd0, dmem_mask}, 1);
      cyc();
    end
    imem_resp = 1;
    @(negedge clk);
    chk_ctrl("mix_c5", ALL);
    chk("mix_c5_dmask", {31'd0, dmem_mask}, 1);
    cyc();
    imem_resp = 0; imem_read = 0; dmem_read = 0;
    chk("mix_after_dmask", {31'd0, dmem_mask}, 0);
    chk("mix_stall", perf_stall, PERF * 7);
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
    @(negedge clk);
    chk_ctrl("lu_rs2", BUB);
    cyc();
    ex_rd = 0; id_rs2 = 0;
    @(negedge clk);
    chk_ctrl("lu_x0", ALL);
    cyc();
    ex_rd = 7; id_rs2 = 7; id_uses_rs2 = 0;
    @(negedge clk);
    chk_ctrl("lu_unused", ALL);
    cyc();
    id_rs1 = 7; id_uses_rs1 = 1;
    @(negedge clk);
    chk_ctrl("lu_rs1", BUB);
    cyc();
    chk("lu_bubble", perf_bubble, PERF * 2);
    ex_br_taken = 1;
    @(negedge clk);
    chk_ctrl("redir", RED);
    cyc();
    ex_br_taken = 0; ex_mem_read = 0; id_uses_rs1 = 0;
    chk("redir_flush", perf_flush, PERF * 1);
    chk("redir_bubble", perf_bubble, PERF * 2);
    imem_read = 1; dmem_write = 1;
    cyc();
    imem_resp = 1;
    cyc();
    imem_resp = 0;
    chk("done_imask", {31'd0, imem_mask}, 1);
    #2;
    rst = 1;
    #1;
    chk("arst_imask", {31'd0, imem_mask}, 0);
    chk_ctrl("arst_ctrl", NONE);
    chk("arst_stall", perf_stall, 0);
    chk("arst_flush", perf_flush, 0);
    imem_read = 0; dmem_write = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk_ctrl("post_rst_ctrl", ALL);
    imem_read = 1;
    #1;
    chk_ctrl("post_rst_idle_req", NONE);
    imem_read = 0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
